id_stage_pipe: RTL and testbench
================================

# id_stage_pipe

Parametrised instruction-decode stage with an integrated ID/EX pipeline register, sitting between the IF/ID register and the execute stage of the 5-stage core. It decodes the fixed 32-bit instruction format, reads and writes the register file, and selects the immediate or register operand. It registers every decoded field with a valid/ready handshake. It also detects load-use hazards against its own output register, inserting a one-cycle bubble, and squashes wrong-path instructions on a branch flush.

## Interface
- DATA_W, 32, datapath and PC width (≥16)
- NUM_REGS, 32, implemented registers (2..32); addresses ≥ NUM_REGS read 0, writes ignored
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  IF/ID holds a valid instruction
- in_ready  out  1  stage accepts instruction this cycle
- pc_in  in  DATA_W  PC of incoming instruction
- inst  in  32  opcode[31:26], src1[25:21], src2[20:16], dest[15:11], imm[15:0]
- wb_en  in  1  write-back enable
- wb_dest  in  5  write-back register
- wb_value  in  DATA_W  write-back data
- flush  in  1  branch taken in EX; squash ID and ID/EX contents
- out_ready  in  1  execute stage accepts output
- out_valid  out  1  outputs hold a live instruction
- pc_out  out  DATA_W  registered pc_in
- out_wb_en, out_mem_read, out_mem_write  out  1 each  registered control
- out_br  out  2  branch type
- out_exe_cmd  out  4  ALU command
- out_data1  out  DATA_W  src1 value
- out_data2  out  DATA_W  sign-extended imm if is_imm, else src2 value
- out_reg2  out  DATA_W  src2 value (store data)
- out_dest  out  5  src2 field if is_imm, else dest field

## Operation
- Control decode comes from the team control table (id_pkg). It yields wb_en, mem_read, mem_write, is_imm, br and exe_cmd. Undefined opcodes decode as NOP, with all enables 0.
- Register file: NUM_REGS × DATA_W. r0 reads 0 and ignores writes. Reads are combinational. Writes happen on the rising edge when wb_en=1.
- Immediate: imm[15:0] is sign-extended to DATA_W.
- uses_src2 = !is_imm | mem_write | (br≠0).
- Hazard: asserted when out_valid & out_mem_read & out_dest≠0 & (out_dest==src1 | (uses_src2 & out_dest==src2)).
- in_ready = flush | (!hazard & (!out_valid | out_ready)).
- Output register update, highest priority first:
  - flush: out_valid←0. The instruction presented this cycle is consumed (in_ready=1) and discarded.
  - out_valid & !out_ready: hold all outputs.
  - hazard: out_valid←0 (bubble). The instruction is not consumed.
  - in_valid: load the decoded fields, out_valid←1.
  - otherwise: out_valid←0.
- When out_valid=0, the registered wb_en, mem_read and mem_write are forced to 0. Other fields are don't-care.

## Timing
- Latency is 1 cycle: an instruction accepted at edge k is on the outputs after edge k.
- Load-use costs exactly one bubble. The dependent instruction is accepted on the following cycle.
- Reset, asynchronous on rst=0:
  - all outputs 0, out_valid 0
  - all registers cleared to 0
  - in_ready is 1 after reset while flush=0 and no hazard
- Reset mid-stall or mid-hold drops the held instruction.
- A write and a read of the same register in one cycle follow the Configuration rule.
- A flush coincident with a hazard or with backpressure still clears the outputs.

## Configuration
- ID_WB_BYPASS_EN defined: if wb_en & wb_dest==src & src≠0, the combinational read returns wb_value in the same cycle. This applies to both read ports and to out_reg2.
- ID_WB_BYPASS_EN undefined: the read returns the pre-write value, and the new value is visible from the next cycle.

## Structure
- Package id_pkg holds:
  - the opcode constants, exe_cmd constants and br encodings
  - a struct for decoded control fields
  - the decode function
  - the field-position constants
- One sub-module, id_regfile. It is parametrised by DATA_W and NUM_REGS, and contains the bypass logic under ID_WB_BYPASS_EN.

## Test plan
- Reset:
  - Stimulus: rst low mid-stream with random inputs.
  - Response: all outputs 0 and out_valid 0 while low. After release, r1..r31 read 0.
- ADDI:
  - Preload r2=5. Present ADDI, src1=r2, src2=r3, imm=0xFFFF.
  - Next cycle: out_data1=5, out_data2=0xFFFFFFFF, out_dest=3, out_wb_en=1.
- Load-use:
  - Present LD to r4, then ADD using r4 as src1.
  - Cycle 2: in_ready=0 and a bubble (out_valid=0).
  - Cycle 3: the ADD appears with out_valid=1.
  - Repeat with dest r0: no stall.
- Flush:
  - Present a valid instruction with flush=1.
  - Response: in_ready=1, and out_valid=0 on the next cycle with mem_write=0.
- Backpressure:
  - Hold out_ready=0 for 3 cycles.
  - Response: outputs stable, in_ready=0. The instruction advances once out_ready=1.
- Bypass:
  - Stimulus: wb_en=1, wb_dest=7, wb_value=0x1234, while decoding src1=r7 (old value 0).
  - Response: out_data1=0x1234 with ID_WB_BYPASS_EN defined, otherwise 0.

Source files
------------

// File: rtl/id_pkg.sv
// Decode-stage shared definitions: instruction field positions, opcode/ALU/branch encodings,
// the decoded-control struct and the control-table decode function.
package id_pkg;

   localparam int unsigned OpcodeMsb = 31;
   localparam int unsigned OpcodeLsb = 26;
   localparam int unsigned Src1Msb   = 25;
   localparam int unsigned Src1Lsb   = 21;
   localparam int unsigned Src2Msb   = 20;
   localparam int unsigned Src2Lsb   = 16;
   localparam int unsigned DestMsb   = 15;
   localparam int unsigned DestLsb   = 11;
   localparam int unsigned ImmMsb    = 15;
   localparam int unsigned ImmLsb    = 0;

   typedef enum logic [5:0] {
      OpNop  = 6'd0,
      OpAdd  = 6'd1,
      OpSub  = 6'd3,
      OpAnd  = 6'd5,
      OpOr   = 6'd6,
      OpNor  = 6'd7,
      OpXor  = 6'd8,
      OpSla  = 6'd9,
      OpSll  = 6'd10,
      OpSra  = 6'd11,
      OpSrl  = 6'd12,
      OpAddi = 6'd32,
      OpSubi = 6'd33,
      OpLd   = 6'd36,
      OpSt   = 6'd37,
      OpBez  = 6'd40,
      OpBne  = 6'd41,
      OpJmp  = 6'd42
   } opcode_e;

   typedef enum logic [3:0] {
      ExeAdd = 4'd0,
      ExeSub = 4'd2,
      ExeAnd = 4'd4,
      ExeOr  = 4'd5,
      ExeNor = 4'd6,
      ExeXor = 4'd7,
      ExeShl = 4'd8,
      ExeSra = 4'd9,
      ExeSrl = 4'd10,
      ExeNop = 4'd15
   } exe_cmd_e;

   typedef enum logic [1:0] {
      BrNone = 2'd0,
      BrBez  = 2'd1,
      BrBne  = 2'd2,
      BrJmp  = 2'd3
   } br_e;

   typedef struct packed {
      logic     wb_en;
      logic     mem_read;
      logic     mem_write;
      logic     is_imm;
      br_e      br;
      exe_cmd_e exe_cmd;
   } ctrl_t;

   function automatic ctrl_t decode(input logic [5:0] op);
      ctrl_t c;
      c.wb_en     = 1'b0;
      c.mem_read  = 1'b0;
      c.mem_write = 1'b0;
      c.is_imm    = 1'b0;
      c.br        = BrNone;
      c.exe_cmd   = ExeNop;
      case (op)
         OpAdd:  begin c.wb_en = 1'b1; c.exe_cmd = ExeAdd; end
         OpSub:  begin c.wb_en = 1'b1; c.exe_cmd = ExeSub; end
         OpAnd:  begin c.wb_en = 1'b1; c.exe_cmd = ExeAnd; end
         OpOr:   begin c.wb_en = 1'b1; c.exe_cmd = ExeOr;  end
         OpNor:  begin c.wb_en = 1'b1; c.exe_cmd = ExeNor; end
         OpXor:  begin c.wb_en = 1'b1; c.exe_cmd = ExeXor; end
         OpSla,
         OpSll:  begin c.wb_en = 1'b1; c.exe_cmd = ExeShl; end
         OpSra:  begin c.wb_en = 1'b1; c.exe_cmd = ExeSra; end
         OpSrl:  begin c.wb_en = 1'b1; c.exe_cmd = ExeSrl; end
         OpAddi: begin c.wb_en = 1'b1; c.is_imm = 1'b1; c.exe_cmd = ExeAdd; end
         OpSubi: begin c.wb_en = 1'b1; c.is_imm = 1'b1; c.exe_cmd = ExeSub; end
         OpLd: begin
            c.wb_en    = 1'b1;
            c.mem_read = 1'b1;
            c.is_imm   = 1'b1;
            c.exe_cmd  = ExeAdd;
         end
         OpSt: begin
            c.mem_write = 1'b1;
            c.is_imm    = 1'b1;
            c.exe_cmd   = ExeAdd;
         end
         OpBez:  begin c.is_imm = 1'b1; c.br = BrBez; end
         OpBne:  begin c.is_imm = 1'b1; c.br = BrBne; end
         OpJmp:  begin c.is_imm = 1'b1; c.br = BrJmp; end
         default: c = c;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// Handshake and data bundle between IF/ID, write-back, execute and the decode stage.
interface id_stage_pipe_if #(
   parameter int unsigned DATA_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] pc_in;
   logic [31:0]       inst;
   logic              wb_en;
   logic [4:0]        wb_dest;
   logic [DATA_W-1:0] wb_value;
   logic              flush;
   logic              out_ready;
   logic              out_valid;
   logic [DATA_W-1:0] pc_out;
   logic              out_wb_en;
   logic              out_mem_read;
   logic              out_mem_write;
   logic [1:0]        out_br;
   logic [3:0]        out_exe_cmd;
   logic [DATA_W-1:0] out_data1;
   logic [DATA_W-1:0] out_data2;
   logic [DATA_W-1:0] out_reg2;
   logic [4:0]        out_dest;

   modport master (
      output in_valid, pc_in, inst, wb_en, wb_dest, wb_value, flush, out_ready,
      input  in_ready, out_valid, pc_out, out_wb_en, out_mem_read, out_mem_write, out_br,
             out_exe_cmd, out_data1, out_data2, out_reg2, out_dest
   );

   modport slave (
      input  in_valid, pc_in, inst, wb_en, wb_dest, wb_value, flush, out_ready,
      output in_ready, out_valid, pc_out, out_wb_en, out_mem_read, out_mem_write, out_br,
             out_exe_cmd, out_data1, out_data2, out_reg2, out_dest
   );

endinterface

// File: rtl/id_regfile.sv
// Two-read one-write register file; r0 and addresses >= NUM_REGS read as zero.
// Same-cycle write-to-read forwarding is enabled by defining ID_WB_BYPASS_EN.
module id_regfile #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        rd_addr1,
   input  logic [4:0]        rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   input  logic              wr_en,
   input  logic [4:0]        wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   localparam int unsigned AddrW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic              byp1;
   logic              byp2;

   function automatic logic in_range(input logic [4:0] a);
      return (a != 5'd0) && (32'(a) < NUM_REGS);
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en && in_range(wr_addr)) begin
         regs_q[wr_addr[AddrW-1:0]] <= wr_data;
      end
   end

`ifdef ID_WB_BYPASS_EN
   assign byp1 = wr_en && in_range(rd_addr1) && (wr_addr == rd_addr1);
   assign byp2 = wr_en && in_range(rd_addr2) && (wr_addr == rd_addr2);
`else
   assign byp1 = 1'b0;
   assign byp2 = 1'b0;
`endif

   always_comb begin
      rd_data1 = '0;
      rd_data2 = '0;
      if (byp1) begin
         rd_data1 = wr_data;
      end else if (in_range(rd_addr1)) begin
         rd_data1 = regs_q[rd_addr1[AddrW-1:0]];
      end
      if (byp2) begin
         rd_data2 = wr_data;
      end else if (in_range(rd_addr2)) begin
         rd_data2 = regs_q[rd_addr2[AddrW-1:0]];
      end
   end

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction decode stage with ID/EX register, load-use bubble insertion and branch flush.
// Define ID_WB_BYPASS_EN to forward same-cycle write-back data into the register reads.
module id_stage_pipe
   import id_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_REGS = 32
) (
   input logic            clk,
   input logic            rst,
   id_stage_pipe_if.slave bus
);

   logic [5:0]        opcode;
   logic [4:0]        src1;
   logic [4:0]        src2;
   logic [4:0]        dest;
   logic [15:0]       imm;
   ctrl_t             ctrl;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;
   logic [DATA_W-1:0] imm_ext;
   logic              uses_src2;
   logic              hazard;

   logic              valid_q,     valid_d;
   logic [DATA_W-1:0] pc_q,        pc_d;
   logic              wb_en_q,     wb_en_d;
   logic              mem_read_q,  mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic [1:0]        br_q,        br_d;
   logic [3:0]        exe_q,       exe_d;
   logic [DATA_W-1:0] data1_q,     data1_d;
   logic [DATA_W-1:0] data2_q,     data2_d;
   logic [DATA_W-1:0] reg2_q,      reg2_d;
   logic [4:0]        dest_q,      dest_d;

   assign opcode  = bus.inst[OpcodeMsb:OpcodeLsb];
   assign src1    = bus.inst[Src1Msb:Src1Lsb];
   assign src2    = bus.inst[Src2Msb:Src2Lsb];
   assign dest    = bus.inst[DestMsb:DestLsb];
   assign imm     = bus.inst[ImmMsb:ImmLsb];
   assign ctrl    = decode(opcode);
   assign imm_ext = DATA_W'($signed(imm));

   id_regfile #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS)
   ) u_regfile (
      .clk      (clk),
      .rst      (rst),
      .rd_addr1 (src1),
      .rd_addr2 (src2),
      .rd_data1 (rd1),
      .rd_data2 (rd2),
      .wr_en    (bus.wb_en),
      .wr_addr  (bus.wb_dest),
      .wr_data  (bus.wb_value)
   );

   // Stores and branches read src2 even though their second ALU operand is the immediate.
   assign uses_src2 = !ctrl.is_imm || ctrl.mem_write || (ctrl.br != BrNone);

   assign hazard = valid_q && mem_read_q && (dest_q != 5'd0) &&
                   ((dest_q == src1) || (uses_src2 && (dest_q == src2)));

   assign bus.in_ready = bus.flush || (!hazard && (!valid_q || bus.out_ready));

   always_comb begin
      valid_d     = valid_q;
      pc_d        = pc_q;
      wb_en_d     = wb_en_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      br_d        = br_q;
      exe_d       = exe_q;
      data1_d     = data1_q;
      data2_d     = data2_q;
      reg2_d      = reg2_q;
      dest_d      = dest_q;
      if (bus.flush) begin
         valid_d = 1'b0;
      end else if (valid_q && !bus.out_ready) begin
         valid_d = 1'b1;
      end else if (hazard) begin
         valid_d = 1'b0;
      end else if (bus.in_valid) begin
         valid_d     = 1'b1;
         pc_d        = bus.pc_in;
         wb_en_d     = ctrl.wb_en;
         mem_read_d  = ctrl.mem_read;
         mem_write_d = ctrl.mem_write;
         br_d        = ctrl.br;
         exe_d       = ctrl.exe_cmd;
         data1_d     = rd1;
         data2_d     = ctrl.is_imm ? imm_ext : rd2;
         reg2_d      = rd2;
         dest_d      = ctrl.is_imm ? src2 : dest;
      end else begin
         valid_d = 1'b0;
      end
      // An empty slot must never carry side-effecting control into execute.
      if (!valid_d) begin
         wb_en_d     = 1'b0;
         mem_read_d  = 1'b0;
         mem_write_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q     <= 1'b0;
         pc_q        <= '0;
         wb_en_q     <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         br_q        <= '0;
         exe_q       <= '0;
         data1_q     <= '0;
         data2_q     <= '0;
         reg2_q      <= '0;
         dest_q      <= '0;
      end else begin
         valid_q     <= valid_d;
         pc_q        <= pc_d;
         wb_en_q     <= wb_en_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         br_q        <= br_d;
         exe_q       <= exe_d;
         data1_q     <= data1_d;
         data2_q     <= data2_d;
         reg2_q      <= reg2_d;
         dest_q      <= dest_d;
      end
   end

   assign bus.out_valid     = valid_q;
   assign bus.pc_out        = pc_q;
   assign bus.out_wb_en     = wb_en_q;
   assign bus.out_mem_read  = mem_read_q;
   assign bus.out_mem_write = mem_write_q;
   assign bus.out_br        = br_q;
   assign bus.out_exe_cmd   = exe_q;
   assign bus.out_data1     = data1_q;
   assign bus.out_data2     = data2_q;
   assign bus.out_reg2      = reg2_q;
   assign bus.out_dest      = dest_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: directed instructions push expected ID/EX contents,
// a negedge monitor pops and compares on every output transfer.
module tb_id_stage_pipe;
   import id_pkg::*;

   localparam int unsigned DW = 32;
`ifdef ID_WB_BYPASS_EN
   localparam logic [31:0] Byp1Exp = 32'h1234;
   localparam logic [31:0] Byp2Exp = 32'h5678;
`else
   localparam logic [31:0] Byp1Exp = 32'h0;
   localparam logic [31:0] Byp2Exp = 32'h1234;
`endif

   typedef struct packed {
      logic [31:0] pc;
      logic        wb_en;
      logic        mem_read;
      logic        mem_write;
      logic [1:0]  br;
      logic [3:0]  exe;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] r2;
      logic [4:0]  dest;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   id_stage_pipe_if #(.DATA_W(DW)) bus ();

   id_stage_pipe #(
      .DATA_W   (DW),
      .NUM_REGS (32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t exp_q[$];
   exp_t mon_act;
   exp_t mon_exp;
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] s1,
                                         input logic [4:0] s2, input logic [4:0] d);
      return {op, s1, s2, d, 11'b0};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s1,
                                         input logic [4:0] s2, input logic [15:0] imm);
      return {op, s1, s2, imm};
   endfunction

   function automatic exp_t ex(input logic [31:0] pc, input logic wb, input logic mr,
                               input logic mw, input logic [1:0] br, input logic [3:0] exe,
                               input logic [31:0] d1, input logic [31:0] d2,
                               input logic [31:0] r2, input logic [4:0] dest);
      exp_t e;
      e.pc = pc; e.wb_en = wb; e.mem_read = mr; e.mem_write = mw; e.br = br; e.exe = exe;
      e.d1 = d1; e.d2 = d2; e.r2 = r2; e.dest = dest;
      return e;
   endfunction

   // Monitor: an output transfers at the next rising edge when valid and ready.
   always @(negedge clk) begin
      if (rst && bus.out_valid && bus.out_ready) begin
         mon_act.pc = bus.pc_out;           mon_act.wb_en = bus.out_wb_en;
         mon_act.mem_read = bus.out_mem_read; mon_act.mem_write = bus.out_mem_write;
         mon_act.br = bus.out_br;           mon_act.exe = bus.out_exe_cmd;
         mon_act.d1 = bus.out_data1;        mon_act.d2 = bus.out_data2;
         mon_act.r2 = bus.out_reg2;         mon_act.dest = bus.out_dest;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected: got output pc=%0h, expected no output", mon_act.pc);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_act !== mon_exp) begin
               n_err++;
               $display("FAIL sb_pc_%0h: got %p expected %p", mon_exp.pc, mon_act, mon_exp);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] ins, input logic [31:0] pc, input exp_t e);
      bit done = 1'b0;
      bus.in_valid = 1'b1;
      bus.inst     = ins;
      bus.pc_in    = pc;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            exp_q.push_back(e);
            done = 1'b1;
         end
         tick();
      end
      bus.in_valid = 1'b0;
      n_cmp++;
      if (!done) begin
         n_err++;
         $display("FAIL accept_pc_%0h: got in_ready=0 for 20 cycles, expected acceptance", pc);
      end
   endtask

   task automatic wb_write(input logic [4:0] r, input logic [31:0] v);
      bus.wb_en    = 1'b1;
      bus.wb_dest  = r;
      bus.wb_value = v;
      tick();
      bus.wb_en = 1'b0;
   endtask

   task automatic randomize_inputs();
      bus.in_valid = 1'($urandom);
      bus.inst     = $urandom;
      bus.pc_in    = $urandom;
      bus.wb_en    = 1'($urandom);
      bus.wb_dest  = 5'($urandom);
      bus.wb_value = $urandom;
      bus.flush    = 1'($urandom);
      bus.out_ready = 1'($urandom);
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_valid"}, bus.out_valid, 0);
      check({tag, "_pc"}, bus.pc_out, 0);
      check({tag, "_ctl"}, {bus.out_wb_en, bus.out_mem_read, bus.out_mem_write, bus.out_br,
                            bus.out_exe_cmd}, 0);
      check({tag, "_data"}, {bus.out_data1, bus.out_data2}, 0);
      check({tag, "_reg2_dest"}, {bus.out_reg2, 27'b0, bus.out_dest}, 0);
   endtask

   initial begin
      rst = 1'b1;
      randomize_inputs();
      #1 rst = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check_cleared("rst_init");
         randomize_inputs();
      end
      tick();
      bus.in_valid = 1'b0; bus.wb_en = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
      bus.inst = '0; bus.pc_in = '0; bus.wb_dest = '0; bus.wb_value = '0;
      rst = 1'b1;
      @(negedge clk);
      check("ready_after_reset", bus.in_ready, 1);
      tick();

      wb_write(5'd2, 32'd5);
      wb_write(5'd6, 32'hA5A5);

      // Directed decode vectors
      send(itype(OpAddi, 2, 3, 16'hFFFF), 32'h100,
           ex(32'h100, 1, 0, 0, BrNone, ExeAdd, 32'd5, 32'hFFFF_FFFF, 32'd0, 5'd3));
      send(rtype(OpSub, 2, 6, 9), 32'h104,
           ex(32'h104, 1, 0, 0, BrNone, ExeSub, 32'd5, 32'hA5A5, 32'hA5A5, 5'd9));
      send(itype(OpSt, 2, 6, 16'h0010), 32'h108,
           ex(32'h108, 0, 0, 1, BrNone, ExeAdd, 32'd5, 32'h10, 32'hA5A5, 5'd6));
      send(itype(OpBne, 2, 6, 16'h8000), 32'h10C,
           ex(32'h10C, 0, 0, 0, BrBne, ExeNop, 32'd5, 32'hFFFF_8000, 32'hA5A5, 5'd6));
      send(rtype(6'h3F, 6, 2, 10), 32'h110,
           ex(32'h110, 0, 0, 0, BrNone, ExeNop, 32'hA5A5, 32'd5, 32'd5, 5'd10));

      // Load-use on src1: one bubble, then the ADD
      send(itype(OpLd, 2, 4, 16'h0008), 32'h120,
           ex(32'h120, 1, 1, 0, BrNone, ExeAdd, 32'd5, 32'd8, 32'd0, 5'd4));
      bus.in_valid = 1'b1; bus.inst = rtype(OpAdd, 4, 2, 5); bus.pc_in = 32'h124;
      @(negedge clk);
      check("lu_stall_ready", bus.in_ready, 0);
      check("lu_ld_valid", bus.out_valid, 1);
      tick();
      @(negedge clk);
      check("lu_bubble_valid", bus.out_valid, 0);
      check("lu_resume_ready", bus.in_ready, 1);
      if (bus.in_ready) exp_q.push_back(ex(32'h124, 1, 0, 0, BrNone, ExeAdd, 32'd0, 32'd5,
                                           32'd5, 5'd5));
      tick();
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("lu_add_valid", bus.out_valid, 1);
      tick();

      // Load to r0 never stalls
      send(itype(OpLd, 2, 0, 16'h0008), 32'h130,
           ex(32'h130, 1, 1, 0, BrNone, ExeAdd, 32'd5, 32'd8, 32'd0, 5'd0));
      bus.in_valid = 1'b1; bus.inst = rtype(OpAdd, 0, 2, 12); bus.pc_in = 32'h134;
      @(negedge clk);
      check("lu_r0_no_stall", bus.in_ready, 1);
      if (bus.in_ready) exp_q.push_back(ex(32'h134, 1, 0, 0, BrNone, ExeAdd, 32'd0, 32'd5,
                                           32'd5, 5'd12));
      tick();

      // ADDI ignores src2, so a load into its src2 field does not stall
      send(itype(OpLd, 2, 9, 16'h0004), 32'h138,
           ex(32'h138, 1, 1, 0, BrNone, ExeAdd, 32'd5, 32'd4, 32'd0, 5'd9));
      bus.in_valid = 1'b1; bus.inst = itype(OpAddi, 6, 9, 16'h0001); bus.pc_in = 32'h13C;
      @(negedge clk);
      check("lu_imm_no_stall", bus.in_ready, 1);
      if (bus.in_ready) exp_q.push_back(ex(32'h13C, 1, 0, 0, BrNone, ExeAdd, 32'hA5A5, 32'd1,
                                           32'd0, 5'd9));
      tick();

      // Branches compare src2, so the same pattern stalls
      send(itype(OpLd, 2, 9, 16'h0004), 32'h140,
           ex(32'h140, 1, 1, 0, BrNone, ExeAdd, 32'd5, 32'd4, 32'd0, 5'd9));
      bus.in_valid = 1'b1; bus.inst = itype(OpBne, 2, 9, 16'h0004); bus.pc_in = 32'h144;
      @(negedge clk);
      check("lu_br_src2_stall", bus.in_ready, 0);
      tick();
      send(itype(OpBne, 2, 9, 16'h0004), 32'h144,
           ex(32'h144, 0, 0, 0, BrBne, ExeNop, 32'd5, 32'd4, 32'd0, 5'd9));

      // Flush coincident with backpressure squashes the held ADDI and the incoming store
      send(itype(OpAddi, 2, 3, 16'h0002), 32'h150,
           ex(32'h150, 1, 0, 0, BrNone, ExeAdd, 32'd5, 32'd2, 32'd0, 5'd3));
      bus.out_ready = 1'b0; bus.flush = 1'b1;
      bus.in_valid = 1'b1; bus.inst = itype(OpSt, 2, 6, 16'h0020); bus.pc_in = 32'h154;
      @(negedge clk);
      check("flush_ready", bus.in_ready, 1);
      tick();
      bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      check("flush_pending_entry", exp_q.size(), 1);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      @(negedge clk);
      check("flush_valid", bus.out_valid, 0);
      check("flush_mem_write", bus.out_mem_write, 0);
      tick();

      // Backpressure: hold three cycles, then advance
      send(rtype(OpAdd, 2, 6, 13), 32'h160,
           ex(32'h160, 1, 0, 0, BrNone, ExeAdd, 32'd5, 32'hA5A5, 32'hA5A5, 5'd13));
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.inst = rtype(OpXor, 6, 2, 14); bus.pc_in = 32'h164;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_ready", bus.in_ready, 0);
         check("bp_hold_pc", bus.pc_out, 32'h160);
         check("bp_hold_data", {bus.out_data1, bus.out_data2}, {32'd5, 32'hA5A5});
         tick();
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_ready", bus.in_ready, 1);
      if (bus.in_ready) exp_q.push_back(ex(32'h164, 1, 0, 0, BrNone, ExeXor, 32'hA5A5, 32'd5,
                                           32'd5, 5'd14));
      tick();
      bus.in_valid = 1'b0;

      // Same-cycle write-back versus read on both ports
      bus.wb_en = 1'b1; bus.wb_dest = 5'd7; bus.wb_value = 32'h1234;
      send(rtype(OpAdd, 7, 0, 8), 32'h170,
           ex(32'h170, 1, 0, 0, BrNone, ExeAdd, Byp1Exp, 32'd0, 32'd0, 5'd8));
      bus.wb_value = 32'h5678;
      send(itype(OpSt, 0, 7, 16'h0000), 32'h174,
           ex(32'h174, 0, 0, 1, BrNone, ExeAdd, 32'd0, 32'd0, Byp2Exp, 5'd7));
      bus.wb_en = 1'b0;
      send(rtype(OpAdd, 7, 7, 8), 32'h178,
           ex(32'h178, 1, 0, 0, BrNone, ExeAdd, 32'h5678, 32'h5678, 32'h5678, 5'd8));

      // Asynchronous reset mid-stream drops the live instruction
      send(itype(OpAddi, 6, 3, 16'h0003), 32'h180,
           ex(32'h180, 1, 0, 0, BrNone, ExeAdd, 32'hA5A5, 32'd3, 32'd0, 5'd3));
      randomize_inputs();
      #2 rst = 1'b0;
      exp_q.delete();
      #1 check_cleared("rst_async");
      @(negedge clk);
      check_cleared("rst_hold");
      tick();
      bus.in_valid = 1'b0; bus.wb_en = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
      rst = 1'b1;

      for (int r = 1; r < 32; r++) begin
         send(rtype(OpAdd, 5'(r), 5'(r), 5'(r)), 32'h200 + 32'(4 * r),
              ex(32'h200 + 32'(4 * r), 1, 0, 0, BrNone, ExeAdd, 32'd0, 32'd0, 32'd0, 5'(r)));
      end

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
      check("sb_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
